seq_det_scheduler: RTL and testbench
====================================

SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter FRAME_LEN, default 8, giving the bits per frame sent serially to the shared Moore detector (2..32).
REQ-003 Port `clk`, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-004 Port `reset`, input, 1 bit: synchronous, active-low reset.
REQ-005 Port `req`, input, N_REQ bits: per-requester frame request, level, held until granted.
REQ-006 Port `frame_data`, input, N_REQ*FRAME_LEN bits: per-requester frame; slice i is at bits [i*FRAME_LEN +: FRAME_LEN].
REQ-007 Port `grant`, output, N_REQ bits: one-hot, one-cycle pulse when the frame of requester i is captured.
REQ-008 Port `busy`, output, 1 bit: high in every state except IDLE.
REQ-009 Port `det_rst`, output, 1 bit: active-high reset to the shared detector.
REQ-010 Port `det_x`, output, 1 bit: serial input to the detector.
REQ-011 Port `det_z`, input, 1 bit: Moore output of the detector.
REQ-012 Port `done`, output, 1 bit: one-cycle pulse when a frame result is valid.
REQ-013 Port `done_id`, output, $clog2(N_REQ) bits: index of the requester the result belongs to.
REQ-014 Port `hit_count`, output, $clog2(FRAME_LEN+1) bits: number of sampled det_z=1 for the frame.
REQ-015 Port `hit_any`, output, 1 bit: equals (hit_count != 0).

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, SHIFT, DRAIN, REPORT.
REQ-017 IDLE, any req bit set: the arbiter picks a winner; grant pulses, the frame is latched into the shift register, and the FSM goes to CLEAR, all in the same cycle.
REQ-018 CLEAR SHALL last exactly 1 cycle with det_rst=1 and det_x=0, then go to SHIFT.
REQ-019 SHIFT SHALL last exactly FRAME_LEN cycles, driving det_x LSB first, one bit per cycle, from a registered output.
REQ-020 det_z SHALL be sampled once per bit, one cycle after that bit is presented: SHIFT cycles 2..FRAME_LEN and the single DRAIN cycle.
REQ-021 hit_count SHALL saturate at FRAME_LEN; by construction it cannot exceed it.
REQ-022 DRAIN SHALL last 1 cycle, then go to REPORT.
REQ-023 REPORT SHALL last 1 cycle with done=1; done_id, hit_count and hit_any SHALL hold until the next REPORT.
REQ-024 After REPORT the FSM SHALL go to IDLE; a new grant is possible on the following cycle.
REQ-025 Total latency from grant to done SHALL be FRAME_LEN+3 cycles.
REQ-026 Default arbitration SHALL be round-robin: priority starts at the index after the last granted requester; first grant after reset starts at index 0.
REQ-027 req changes while busy SHALL be ignored until IDLE.
REQ-028 A req dropped before grant SHALL be treated as withdrawn, with no error.
REQ-029 frame_data SHALL be sampled only in the grant cycle.
REQ-030 det_rst SHALL be 0 in all states except CLEAR.

Reset
REQ-031 While reset=0 at a clock edge: FSM to IDLE, grant=0, busy=0, det_rst=1, det_x=0, done=0, done_id=0, hit_count=0, hit_any=0, round-robin pointer=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no done pulse; the aborted requester is not re-granted automatically.

Configuration
REQ-033 With SEQ_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority, lowest index wins, with no round-robin pointer.
REQ-034 Without SEQ_SCHED_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-026.

Structure
REQ-035 Package seq_sched_pkg SHALL hold the FSM state enum, the CLEAR/DRAIN/REPORT cycle-count constants and the default parameter values.
REQ-036 The arbiter SHALL be a separate sub-module, rr_arbiter (req, grant_en -> one-hot grant), which contains the SEQ_SCHED_FIXED_PRIO_EN option.

Verification
Detector model for all scenarios: a Moore register where z is x delayed by one cycle and cleared by det_rst, so hit_count = popcount(frame).
REQ-037 Scenario 1: after reset, req=4'b0001, frame0=8'hA5 -> grant=0001 for 1 cycle; det_x sequence 1,0,1,0,0,1,0,1; done at grant+11; done_id=0, hit_count=4, hit_any=1.
REQ-038 Scenario 2: req=4'b1111 held, distinct frames -> grants in order 0,1,2,3,0; each done_id matches its grant.
REQ-039 Scenario 3: frame=8'h00 -> hit_count=0, hit_any=0; frame=8'hFF -> hit_count=8.
REQ-040 Scenario 4: reset=0 at SHIFT cycle 3 -> next cycle FSM in IDLE, det_rst=1, no done pulse; after release, req pending -> clean new grant.
REQ-041 Scenario 5: req=4'b0100 then req=4'b0010 raised while busy -> second grant only after REPORT, at the earliest one cycle after done.
REQ-042 Scenario 6: build with SEQ_SCHED_FIXED_PRIO_EN, req=4'b1010 held -> every grant goes to index 1.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// ------------------------------------------------------------------
// seq_sched_pkg: shared FSM states, phase lengths, default sizes
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package seq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    SHIFT  = 3'd2,
    DRAIN  = 3'd3,
    REPORT = 3'd4
  } state_t;

  localparam int CLEAR_CYCLES      = 1;
  localparam int DRAIN_CYCLES      = 1;
  localparam int REPORT_CYCLES     = 1;
  localparam int DEFAULT_N_REQ     = 4;
  localparam int DEFAULT_FRAME_LEN = 8;

endpackage

`default_nettype wire

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter: one-hot request arbiter, round-robin or fixed priority
// Rev 1.0  | option: SEQ_SCHED_FIXED_PRIO_EN selects lowest-index-wins
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import seq_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_en,
  output logic [N_REQ-1:0] grant
);

  localparam int IDX_W = $clog2(N_REQ);

`ifdef SEQ_SCHED_FIXED_PRIO_EN
  // Descending scan so the lowest requesting index is the last writer.
  always_comb begin
    grant = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (grant_en && req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] win;
  logic             found;

  // Scan starts at ptr, the index after the last winner.
  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    if (grant_en && found) begin
      grant[win] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr <= '0;
    end else if (grant_en && found) begin
      ptr <= (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/seq_det_scheduler.sv
// ------------------------------------------------------------------
// seq_det_scheduler: serialises requester frames into a shared Moore detector
// Rev 1.0  | option: SEQ_SCHED_FIXED_PRIO_EN (fixed-priority arbitration)
// ------------------------------------------------------------------
`default_nettype none

module seq_det_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_REQ     = DEFAULT_N_REQ,
  parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ*FRAME_LEN-1:0]     frame_data,
  output logic [N_REQ-1:0]               grant,
  output logic                           busy,
  output logic                           det_rst,
  output logic                           det_x,
  input  logic                           det_z,
  output logic                           done,
  output logic [$clog2(N_REQ)-1:0]       done_id,
  output logic [$clog2(FRAME_LEN+1)-1:0] hit_count,
  output logic                           hit_any
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int BIT_W = $clog2(FRAME_LEN);

  state_t               state;
  logic [FRAME_LEN-1:0] shreg;
  logic [BIT_W-1:0]     bit_cnt;
  logic [CNT_W-1:0]     acc;
  logic [CNT_W-1:0]     acc_next;
  logic [ID_W-1:0]      cur_id;
  logic [ID_W-1:0]      win_id;
  logic [FRAME_LEN-1:0] win_frame;
  logic                 grant_en;

  assign grant_en = reset && (state == IDLE);
  assign acc_next = (acc == CNT_W'(FRAME_LEN)) ? acc : acc + CNT_W'(det_z);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grant_en (grant_en),
    .grant    (grant)
  );

  always_comb begin
    win_id    = '0;
    win_frame = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_id    = ID_W'(i);
        win_frame = frame_data[i*FRAME_LEN +: FRAME_LEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      det_rst   <= 1'b1;
      det_x     <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      hit_count <= '0;
      hit_any   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      acc       <= '0;
      cur_id    <= '0;
    end else begin
      done    <= 1'b0;
      det_rst <= 1'b0;
      case (state)
        IDLE: begin
          if (|grant) begin
            shreg   <= win_frame;
            cur_id  <= win_id;
            det_rst <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          det_x   <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
          acc     <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          // det_z reflects the previous bit, so the first shift cycle has nothing to sample.
          if (bit_cnt != '0) begin
            acc <= acc_next;
          end
          if (bit_cnt == BIT_W'(FRAME_LEN - 1)) begin
            det_x <= 1'b0;
            state <= DRAIN;
          end else begin
            det_x   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DRAIN: begin
          hit_count <= acc_next;
          hit_any   <= (acc_next != '0);
          done      <= 1'b1;
          done_id   <= cur_id;
          state     <= REPORT;
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_det_scheduler.sv
// ------------------------------------------------------------------
// tb_seq_det_scheduler: directed checks of seq_det_scheduler with a delay-line detector
// Rev 1.0  | honours SEQ_SCHED_FIXED_PRIO_EN for the arbitration scenario
// ------------------------------------------------------------------
`default_nettype none

module tb_seq_det_scheduler;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic [3:0]  req        = '0;
  logic [31:0] frame_data = '0;
  logic [3:0]  grant;
  logic        busy;
  logic        det_rst;
  logic        det_x;
  logic        det_z;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  hit_count;
  logic        hit_any;
  logic        z_q;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  seq_det_scheduler #(.N_REQ(4), .FRAME_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .frame_data (frame_data),
    .grant      (grant),
    .busy       (busy),
    .det_rst    (det_rst),
    .det_x      (det_x),
    .det_z      (det_z),
    .done       (done),
    .done_id    (done_id),
    .hit_count  (hit_count),
    .hit_any    (hit_any)
  );

  always #5 clk = ~clk;

  // Moore detector: z is x delayed one cycle, cleared by det_rst.
  always @(posedge clk) z_q <= det_rst ? 1'b0 : det_x;
  assign det_z = z_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Entered at a falling edge with the FSM in IDLE; returns one cycle after done.
  task automatic do_frame(input string tag, input logic [3:0] r_start, input logic [3:0] r_busy,
                          input logic [3:0] exp_grant, input logic [1:0] exp_id,
                          input logic [7:0] exp_bits, input logic [3:0] exp_hits);
    int         n;
    logic [7:0] seen;
    logic       ctl_ok;
    req = r_start;
    #1;
    check({tag, "_grant"}, grant, exp_grant);
    n      = 0;
    seen   = '0;
    ctl_ok = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) req = r_busy;
      if (grant !== 4'b0000 || busy !== 1'b1 || det_rst !== (n == 1)) ctl_ok = 1'b0;
      if (n >= 2 && n <= 9) seen[n-2] = det_x;
      if (done === 1'b1) break;
    end
    check({tag, "_latency"}, n, 11);
    check({tag, "_ctl"}, ctl_ok, 1'b1);
    check({tag, "_det_x"}, seen, exp_bits);
    check({tag, "_done_id"}, done_id, exp_id);
    check({tag, "_hit_count"}, hit_count, exp_hits);
    check({tag, "_hit_any"}, hit_any, exp_hits != 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {done, busy}, 2'b00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 4'b0000);
    check("rst_busy", busy, 1'b0);
    check("rst_det_rst", det_rst, 1'b1);
    check("rst_det_x", det_x, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_outputs", {done_id, hit_count, hit_any}, 7'd0);
    reset = 1'b1;

    frame_data = 32'h0000_00A5;
    do_frame("s1", 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'hA5, 4'd4);

    pulse_reset();
    frame_data = 32'h0F07_0301;
    do_frame("s2a", 4'b1111, 4'b1111, 4'b0001, 2'd0, 8'h01, 4'd1);
    do_frame("s2b", 4'b1111, 4'b1111, 4'b0010, 2'd1, 8'h03, 4'd2);
    do_frame("s2c", 4'b1111, 4'b1111, 4'b0100, 2'd2, 8'h07, 4'd3);
    do_frame("s2d", 4'b1111, 4'b1111, 4'b1000, 2'd3, 8'h0F, 4'd4);
    do_frame("s2e", 4'b1111, 4'b0000, 4'b0001, 2'd0, 8'h01, 4'd1);

    frame_data = 32'h0000_0000;
    do_frame("s3a", 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'h00, 4'd0);
    frame_data = 32'h0000_00FF;
    do_frame("s3b", 4'b0001, 4'b0000, 4'b0001, 2'd0, 8'hFF, 4'd8);

    pulse_reset();
    frame_data = 32'h0000_5500;
    req = 4'b0010;
    #1;
    check("s4_grant", grant, 4'b0010);
    repeat (4) @(negedge clk);
    check("s4_shift3_det_x", {busy, det_x}, 2'b11);
    reset = 1'b0;
    @(negedge clk);
    check("s4_abort_state", {grant, busy, det_rst, det_x, done}, 8'b0000_0100);
    @(negedge clk);
    check("s4_abort_no_done", done, 1'b0);
    reset = 1'b1;
    do_frame("s4", 4'b0010, 4'b0000, 4'b0010, 2'd1, 8'h55, 4'd4);

    frame_data = 32'h003C_8100;
    do_frame("s5a", 4'b0100, 4'b0010, 4'b0100, 2'd2, 8'h3C, 4'd4);
    do_frame("s5b", 4'b0010, 4'b0000, 4'b0010, 2'd1, 8'h81, 4'd2);

    pulse_reset();
    frame_data = 32'hF000_0F00;
    do_frame("s6a", 4'b1010, 4'b1010, 4'b0010, 2'd1, 8'h0F, 4'd4);
`ifdef SEQ_SCHED_FIXED_PRIO_EN
    do_frame("s6b", 4'b1010, 4'b1010, 4'b0010, 2'd1, 8'h0F, 4'd4);
`else
    do_frame("s6b", 4'b1010, 4'b1010, 4'b1000, 2'd3, 8'hF0, 4'd4);
`endif
    do_frame("s6c", 4'b1010, 4'b0000, 4'b0010, 2'd1, 8'h0F, 4'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
